// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux select round-robin arbiter: channel count,
// select index width, FSM state encoding and index-to-one-hot conversion.
package mux_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching ptr+1, ptr+2,
// ptr+3, ptr (mod 4). The result is registered by the arbiter top.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // i == NUM_CH wraps back to ptr itself, giving the last owner lowest priority
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator driving the 4:1 mux selects, with one idle
// cycle per handoff. Optional forced release after MAX_HOLD cycles: ARB_TIMEOUT_EN.
module mux_sel_rr_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       valid,
    output logic       sel1,
    output logic       sel0,
    output logic       timeout
);

    import mux_arb_pkg::*;

    if (NUM_CH != mux_arb_pkg::NUM_CH) begin : g_bad_num_ch
        $error("mux_sel_rr_arbiter: NUM_CH must be 4");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 16) begin : g_bad_max_hold
        $error("mux_sel_rr_arbiter: MAX_HOLD must be in 2..16");
    end
    if ((2 ** CNT_W) < MAX_HOLD) begin : g_bad_cnt_w
        $error("mux_sel_rr_arbiter: CNT_W too narrow for MAX_HOLD");
    end

    arb_state_e       state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel;
    logic             rel_any;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             force_rel;
`endif

    rr_pick u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        rel     = 1'b0;
        rel_any = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        force_rel = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = idx_to_onehot(pick_idx);
                    valid_d = 1'b1;
                    sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                rel     = done | ~req[sel_q];
                rel_any = rel;
`ifdef ARB_TIMEOUT_EN
                // forced release fires only when the owner would otherwise keep the mux
                force_rel = !rel && (cnt_q == CNT_W'(MAX_HOLD - 1));
                cnt_d     = cnt_q + CNT_W'(1);
                timeout_d = force_rel;
                rel_any   = rel | force_rel;
`endif
                if (rel_any) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(NUM_CH - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign valid = valid_q;
    assign sel1  = sel_q[1];
    assign sel0  = sel_q[0];
`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed self-checking bench for mux_sel_rr_arbiter; follows ARB_TIMEOUT_EN
// so the hold-length scenario matches the build.
module tb_mux_sel_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       valid;
    logic       sel1;
    logic       sel0;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    mux_sel_rr_arbiter #(.NUM_CH(4), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .valid   (valid),
        .sel1    (sel1),
        .sel0    (sel0),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {grant[3:0], valid, sel1, sel0, timeout}
    function automatic logic [7:0] obs();
        return {grant, valid, sel1, sel0, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; req = 4'b1111; done = 1'b1;
        tick();
        exp = 8'b0000_0_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs(), exp);
        end
        rst = 1'b0; req = 4'b0000; done = 1'b0;
        tick();
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_idle_hold: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        do_reset();
        req = 4'b0001;
        tick();
        exp = 8'b0001_1_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL single_grant: got %b want %b", obs(), exp);
        end
        req = 4'b0000;
        tick();
        exp = 8'b0000_0_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL single_release: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_s [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [7:0] exp;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = {exp_g[i], 1'b1, exp_s[i], 1'b0};
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs() !== exp) begin
                    errors++;
                    $display("FAIL rotation_grant[%0d] cyc%0d: got %b want %b", i, c, obs(), exp);
                end
                if (c < 2) tick();
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            exp = {4'b0000, 1'b0, exp_s[i], 1'b0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL rotation_gap[%0d]: got %b want %b", i, obs(), exp);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_ignore_others();
        logic [3:0] pat [4] = '{4'b0101, 4'b1100, 4'b1101, 4'b0100};
        logic [7:0] exp;
        do_reset();
        req = 4'b0100;
        tick();
        exp = 8'b0100_1_10_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL ignore_first_grant: got %b want %b", obs(), exp);
        end
        for (int i = 0; i < 4; i++) begin
            req = pat[i];
            tick();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL ignore_hold[%0d]: got %b want %b", i, obs(), exp);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        exp  = 8'b0000_0_10_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL ignore_release: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_simul_release();
        logic [7:0] exp;
        do_reset();
        req = 4'b0010;
        tick();
        exp = 8'b0010_1_01_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL simul_grant1: got %b want %b", obs(), exp);
        end
        req = 4'b0000; done = 1'b1;
        tick();
        done = 1'b0; req = 4'b0011;
        exp = 8'b0000_0_01_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL simul_release: got %b want %b", obs(), exp);
        end
        tick();
        exp = 8'b0001_1_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL simul_next_ch0: got %b want %b", obs(), exp);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        exp = 8'b0010_1_01_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL simul_rotate_ch1: got %b want %b", obs(), exp);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] exp;
        do_reset();
        req = 4'b1000;
        tick();
        exp = 8'b1000_1_11_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL midrst_grant3: got %b want %b", obs(), exp);
        end
        rst = 1'b1; done = 1'b1;
        tick();
        rst = 1'b0; done = 1'b0;
        exp = 8'b0000_0_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL midrst_reset: got %b want %b", obs(), exp);
        end
        tick();
        exp = 8'b1000_1_11_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL midrst_regrant: got %b want %b", obs(), exp);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_done_in_idle();
        logic [7:0] exp;
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0100;
        exp  = 8'b0000_0_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL idle_done_ignored: got %b want %b", obs(), exp);
        end
        tick();
        exp = 8'b0100_1_10_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL idle_done_then_grant: got %b want %b", obs(), exp);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_hold_length();
        logic [7:0] exp;
        do_reset();
        req = 4'b0001;
        tick();
        exp = 8'b0001_1_00_0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL timeout_hold cyc%0d: got %b want %b", c, obs(), exp);
            end
            tick();
        end
        exp = 8'b0000_0_00_1;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL timeout_pulse: got %b want %b", obs(), exp);
        end
        tick();
        exp = 8'b0001_1_00_0;
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL timeout_regrant: got %b want %b", obs(), exp);
        end
`else
        for (int c = 0; c < 22; c++) begin
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL hold_no_timeout cyc%0d: got %b want %b", c, obs(), exp);
            end
            tick();
        end
`endif
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_ignore_others();
        test_simul_release();
        test_reset_mid_grant();
        test_done_in_idle();
        test_hold_length();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
